// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Sequential RV32 M-extension unit. Shift-add multiply and
//                restoring divide on operand magnitudes, one iteration per
//                cycle, with a valid/ready request and response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [4:0]        cnt_q;
    logic              fin_q;       // last iteration done, publish next edge
    logic              pend_q;      // special-case result waiting to be shown
    logic [2:0]        op_q;        // low op bits select the operation
    logic [XLEN-1:0]   acc_q;       // product high half / partial remainder
    logic [XLEN-1:0]   lo_q;        // multiplier & product low half / quotient
    logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic              neg_q;       // negate the magnitude result at the end
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   result_q;
    logic              busy_q;

    logic              sa_d, sb_d, is_div_d, special_d;
    logic [XLEN-1:0]   amag_d, bmag_d, special_res_d;
    logic [XLEN:0]     mul_sum_d, div_shift_d, div_diff_d;
    logic [XLEN-1:0]   acc_d, lo_d, quo_s_d, rem_s_d, final_res_d;
    logic [2*XLEN-1:0] prod_s_d;

    // Operand decode at accept, per-cycle iteration step and final sign fix-up
    always_comb begin
        is_div_d = op[2];
        sa_d = a[XLEN-1] && (op == OP_MUL || op == OP_MULH || op == OP_MULHSU ||
                             op == OP_DIV || op == OP_REM);
        sb_d = b[XLEN-1] && (op == OP_MUL || op == OP_MULH ||
                             op == OP_DIV || op == OP_REM);
        amag_d = sa_d ? -a : a;
        bmag_d = sb_d ? -b : b;

        // Unsupported codes, divide by zero and signed overflow bypass CALC
        special_d     = 1'b0;
        special_res_d = '0;
        if (op[4:3] != 2'b10) begin
            special_d = 1'b1;
        end else if (is_div_d && b == '0) begin
            special_d     = 1'b1;
            special_res_d = op[1] ? a : '1;
        end else if (is_div_d && !op[0] && a == INT_MIN && b == '1) begin
            special_d     = 1'b1;
            special_res_d = op[1] ? '0 : INT_MIN;
        end

        // Shift-add: conditionally add multiplicand, shift {acc,lo} right
        mul_sum_d = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // Restoring divide: shift {acc,lo} left, trial-subtract divisor
        div_shift_d = {acc_q, lo_q[XLEN-1]};
        div_diff_d  = div_shift_d - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_diff_d[XLEN]) begin
                acc_d = div_diff_d[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = div_shift_d[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = mul_sum_d[XLEN:1];
            lo_d  = {mul_sum_d[0], lo_q[XLEN-1:1]};
        end

        prod_s_d = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
        quo_s_d  = neg_q ? -lo_q  : lo_q;
        rem_s_d  = neg_q ? -acc_q : acc_q;
        if (op_q[2])
            final_res_d = op_q[1] ? rem_s_d : quo_s_d;
        else if (op_q[1:0] == 2'b00)
            final_res_d = prod_s_d[XLEN-1:0];
        else
            final_res_d = prod_s_d[2*XLEN-1:XLEN];
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fin_q        <= 1'b0;
            pend_q       <= 1'b0;
            op_q         <= '0;
            acc_q        <= '0;
            lo_q         <= '0;
            opnd_q       <= '0;
            neg_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            busy_q       <= 1'b0;
        end else if (flush) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            fin_q        <= 1'b0;
            pend_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= op[2:0];
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        fin_q       <= 1'b0;
                        if (special_d) begin
                            // Result is parked in acc_q and shown one edge later
                            state_q <= S_DONE;
                            pend_q  <= 1'b1;
                            acc_q   <= special_res_d;
                        end else begin
                            state_q <= S_CALC;
                            acc_q   <= '0;
                            lo_q    <= is_div_d ? amag_d : bmag_d;
                            opnd_q  <= is_div_d ? bmag_d : amag_d;
                            neg_q   <= is_div_d ? (op[1] ? sa_d : (sa_d ^ sb_d))
                                                : (sa_d ^ sb_d);
                        end
                    end
                end
                S_CALC: begin
                    if (fin_q) begin
                        state_q      <= S_DONE;
                        fin_q        <= 1'b0;
                        resp_valid_q <= 1'b1;
                        result_q     <= final_res_d;
                    end else begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31)
                            fin_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (pend_q) begin
                        pend_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        result_q     <= acc_q;
                    end else if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        result_q     <= '0;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    result_q     <= '0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign result     = result_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq; directed cases plus
//                randomized operations against a plain-arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [4:0]  op;
    logic [31:0] a, b, result;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result from the ISA definition using wide arithmetic
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0]        ux, uy, p;
        int                 ix, iy;
        logic               ovf;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'h0, x};
        uy = {32'h0, y};
        ix = x;
        iy = y;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            5'd16: begin p = ux * uy; return p[31:0]; end
            5'd17: begin p = sx * sy; return p[63:32]; end
            5'd18: begin p = sx * uy; return p[63:32]; end
            5'd19: begin p = ux * uy; return p[63:32]; end
            5'd20: return (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ix / iy);
            5'd21: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd22: return (y == 0) ? x : ovf ? 32'h0 : 32'(ix % iy);
            5'd23: return (y == 0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o < 5'd16 || o > 5'd23) return 1;
        if (o >= 5'd20 && y == 0) return 1;
        if ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic accept(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        check("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        op = o; a = x; b = y; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int hold);
        int          lat = 0;
        logic        ok = 1'b1;
        logic [31:0] held;
        int          elat;
        elat = lat_model(o, x, y);
        resp_ready = 1'b0;
        accept(o, x, y);
        while (!resp_valid && lat < 40) begin
            if (!busy || result != 0 || req_ready) ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_wait"}, {31'b0, ok}, 32'd1);
        check({tag, "_res"}, result, exp);
        held = result;
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!resp_valid || result != held || req_ready || !busy) ok = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, {31'b0, ok}, 32'd1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_post"}, {29'b0, resp_valid, req_ready, busy}, 32'b010);
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        op = '0; a = '0; b = '0;
        step(); step();
        rst = 1'b0;
        check("reset", {28'b0, req_ready, resp_valid, busy, |result}, 32'b1000);

        // Directed cases with expectations taken straight from the ISA
        run_op("mul7x6",   5'd16, 32'd7,        32'd6,        32'h0000_002A, 0);
        run_op("mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu",   5'd18, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 0);
        run_op("mulh",     5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
        run_op("div_m7",   5'd20, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0);
        run_op("rem_m7",   5'd22, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0);
        run_op("divu",     5'd21, 32'd100,      32'd7,        32'd14,        0);
        run_op("remu",     5'd23, 32'd100,      32'd7,        32'd2,         0);
        run_op("divu_z",   5'd21, 32'd5,        32'd0,        32'hFFFF_FFFF, 0);
        run_op("rem_z",    5'd22, 32'd5,        32'd0,        32'd5,         0);
        run_op("div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2);
        run_op("bad_op",   5'd5,  32'd9,        32'd9,        32'h0,         1);
        run_op("hold5",    5'd16, 32'd1234,     32'd5678,     32'd7006652,   5);

        // Flush at counter 10: immediate idle, then accept on the next edge
        accept(5'd16, 32'd7, 32'd6);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush", {28'b0, req_ready, resp_valid, busy, |result}, 32'b1000);
        run_op("after_flush", 5'd21, 32'd1000, 32'd3, 32'd333, 0);

        // Reset at counter 20 drops the operation
        accept(5'd17, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset", {28'b0, req_ready, resp_valid, busy, |result}, 32'b1000);
        run_op("mul3x3", 5'd16, 32'd3, 32'd3, 32'd9, 0);

        // Randomized operations, including edge operands
        for (int i = 0; i < 40; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'(16 + $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 200);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 50);
                default: rb = $urandom;
            endcase
            run_op("rand", ro, ra, rb, model(ro, ra, rb), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
